// File: rtl/peak_pkg.sv
// Shared types and constants for the peak_fetch instruction-fetch unit.
package peak_pkg;

  // Instruction substituted for any word that came back with a bus error.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Builds the buffer entry for a memory response; errored words become NOPs.
  function automatic fetch_entry_t make_entry(input logic [31:0] inst,
                                              input logic [31:0] pc,
                                              input logic        err);
    fetch_entry_t e;
    e.inst = err ? NOP_INST : inst;
    e.pc   = pc;
    e.err  = err;
    return e;
  endfunction

endpackage

// File: rtl/peak_fetch_fifo.sv
// Instruction buffer for peak_fetch: small FIFO with push, pop, flush and
// an occupancy count. A flush in the same cycle as a push leaves exactly the
// pushed entry in the buffer (used to inject a single fault entry).
module peak_fetch_fifo
  import peak_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_data,
  output logic [ENTRY_W-1:0] o_data,
  output logic [2:0]         o_count
);

  localparam int AW = (DEPTH > 2) ? 2 : 1;

  fetch_entry_t    r_mem [0:DEPTH-1];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [2:0]      r_count;
  logic [AW-1:0]   w_wr_idx;

  assign w_wr_idx = i_flush ? '0 : r_wr;
  assign o_data   = r_mem[r_rd];
  assign o_count  = r_count;

  // Pointer and occupancy bookkeeping; flush restarts both pointers at slot 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= i_push ? AW'(1) : '0;
      r_count <= i_push ? 3'd1 : 3'd0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + {2'b00, i_push} - {2'b00, i_pop};
    end
  end

  // Entry storage carries no reset; validity comes from the count alone.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[w_wr_idx] <= fetch_entry_t'(i_data);
  end

endmodule

// File: rtl/peak_fetch.sv
// peak_fetch: instruction fetch unit with in-order memory requests, a small
// instruction buffer and redirect/kill handling.
// Optional build macro: PEAK_FETCH_MISALIGN_EN -- a misaligned redirect
// target produces a single error entry instead of being rounded down.
module peak_fetch
  import peak_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        I_MEM_REQ,
  output logic [31:0] I_MEM_ADDR,
  input  logic        I_MEM_GNT,
  input  logic        I_MEM_RVALID,
  input  logic [31:0] I_MEM_RDATA,
  input  logic        I_MEM_ERR,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IF_VALID,
  input  logic        IF_READY,
  output logic [31:0] IF_INST,
  output logic [31:0] IF_PC,
  output logic        IF_ERR
);

  localparam logic [3:0] DEPTH_L = 4'(BUF_DEPTH);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        r_rsp_pc;
  logic [2:0]         r_outst;
  logic [2:0]         r_kill;

  logic [2:0]         w_count;
  logic [ENTRY_W-1:0] w_head_raw;
  fetch_entry_t       w_head;
  fetch_entry_t       w_push_entry;
  logic               w_valid;
  logic               w_pop;
  logic               w_err_pop;
  logic               w_flush;
  logic               w_gnt;
  logic               w_rsp;
  logic               w_rsp_live;
  logic               w_push;
  logic               w_misal;
  logic [31:0]        w_redir_pc;
  logic [2:0]         w_outst_nxt;
  logic [3:0]         w_occupancy;

`ifdef PEAK_FETCH_MISALIGN_EN
  assign w_misal    = REDIRECT & (REDIRECT_PC[1:0] != 2'b00);
  assign w_redir_pc = REDIRECT_PC;
`else
  assign w_misal    = 1'b0;
  assign w_redir_pc = REDIRECT_PC & 32'hFFFF_FFFC;
`endif

  assign w_head    = fetch_entry_t'(w_head_raw);
  assign w_valid   = (w_count != 3'd0);
  assign w_pop     = w_valid & IF_READY;
  assign w_err_pop = w_pop & w_head.err;
  assign w_flush   = REDIRECT | w_err_pop;

  // A response with nothing outstanding (e.g. left over from before reset) is ignored.
  assign w_gnt       = I_MEM_REQ & I_MEM_GNT;
  assign w_rsp       = I_MEM_RVALID & (r_outst != 3'd0);
  assign w_rsp_live  = w_rsp & (r_kill == 3'd0);
  assign w_outst_nxt = r_outst + {2'b00, w_gnt} - {2'b00, w_rsp};

  // Responses behind an accepted error entry, or arriving in FAULT, are dropped.
  assign w_push = w_misal | (w_rsp_live & (r_state == ST_RUN) & ~w_flush);
  assign w_push_entry = w_misal ? make_entry(32'h0, REDIRECT_PC, 1'b1)
                                : make_entry(I_MEM_RDATA, r_rsp_pc, I_MEM_ERR);

  // Slot accounting: buffered + in flight, crediting a clean entry leaving this
  // cycle so a single-cycle memory can sustain one fetch per clock.
  assign w_occupancy = {1'b0, w_count} + {1'b0, r_outst}
                     - {3'b000, w_pop & ~w_head.err};

  assign I_MEM_ADDR = r_pc;
  assign IF_VALID   = w_valid;
  assign IF_INST    = w_valid ? w_head.inst : 32'h0;
  assign IF_PC      = w_valid ? w_head.pc   : 32'h0;
  assign IF_ERR     = w_valid & w_head.err;

  peak_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop & ~w_flush),
    .i_data  (w_push_entry),
    .o_data  (w_head_raw),
    .o_count (w_count)
  );

  // Fetch state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // Next state and request generation; a redirect overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    I_MEM_REQ   = 1'b0;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!REDIRECT && (w_occupancy < DEPTH_L)) I_MEM_REQ = 1'b1;
        if (w_err_pop) w_state_nxt = ST_FAULT;
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_BOOT;
    endcase
    if (REDIRECT) w_state_nxt = w_misal ? ST_FAULT : ST_RUN;
  end

  // Fetch PC, response PC and in-flight / kill counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc     <= RESET_VECTOR;
      r_rsp_pc <= RESET_VECTOR;
      r_outst  <= 3'd0;
      r_kill   <= 3'd0;
    end else begin
      r_outst <= w_outst_nxt;
      if (REDIRECT) begin
        r_pc     <= w_redir_pc;
        r_rsp_pc <= w_redir_pc;
        r_kill   <= w_outst_nxt;
      end else begin
        if (w_gnt)      r_pc     <= r_pc + 32'd4;
        if (w_rsp_live) r_rsp_pc <= r_rsp_pc + 32'd4;
        if (w_rsp && (r_kill != 3'd0)) r_kill <= r_kill - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_peak_fetch.sv
// Testbench for peak_fetch: in-order memory model, expected-entry scoreboard,
// redirect table and hand-written error / stall / reset sequences.
module tb_peak_fetch;
  import peak_pkg::*;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        I_MEM_REQ;
  logic [31:0] I_MEM_ADDR;
  logic        I_MEM_GNT = 1'b0;
  logic        I_MEM_RVALID = 1'b0;
  logic [31:0] I_MEM_RDATA = 32'h0;
  logic        I_MEM_ERR = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        IF_VALID;
  logic        IF_READY = 1'b0;
  logic [31:0] IF_INST;
  logic [31:0] IF_PC;
  logic        IF_ERR;

  always #5 CLK = ~CLK;

  peak_fetch #(.RESET_VECTOR(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .I_MEM_REQ(I_MEM_REQ), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_GNT(I_MEM_GNT),
    .I_MEM_RVALID(I_MEM_RVALID), .I_MEM_RDATA(I_MEM_RDATA), .I_MEM_ERR(I_MEM_ERR),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IF_VALID(IF_VALID), .IF_READY(IF_READY), .IF_INST(IF_INST), .IF_PC(IF_PC),
    .IF_ERR(IF_ERR)
  );

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    bit          hold;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  fetch_entry_t expq[$];
  logic [31:0]  memq[$];
  logic [31:0]  exp_addr = 32'h0;
  int           discard = 0;
  bit           drop = 0;
  bit           gnt_en = 1, gnt_rand = 0, rdy = 1, rdy_rand = 0, mem_hold = 0;
  bit           err_en = 0;
  logic [31:0]  err_pc = 32'h0;
  bit           redir_req = 0;
  logic [31:0]  redir_pc = 32'h0, redir_exp = 32'h0;
  int           grants = 0, pops = 0, req_after_err = 0, req_seen = 0;
  bit           first_seen = 0, err_popped = 0, wrap_seen = 0;
  logic [31:0]  first_pc = 32'h0, last_gnt_addr = 32'h0;
  bit           prev_req = 0, prev_gnt = 0, prev_errpop = 0;
  logic [31:0]  prev_addr = 32'h0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, then sample and score.
  task automatic tick();
    logic [31:0]  a;
    bit           do_rsp;
    fetch_entry_t e;
    @(negedge CLK);
    I_MEM_GNT   = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_en;
    IF_READY    = rdy_rand ? 1'($urandom_range(0, 1)) : rdy;
    REDIRECT    = redir_req;
    REDIRECT_PC = redir_pc;
    do_rsp = (memq.size() != 0) && !mem_hold;
    I_MEM_RVALID = do_rsp;
    I_MEM_RDATA  = 32'h0;
    I_MEM_ERR    = 1'b0;
    if (do_rsp) begin
      a = memq.pop_front();
      I_MEM_RDATA = inst_of(a);
      I_MEM_ERR   = err_en && (a == err_pc);
      if (redir_req) begin
        // flushed along with the buffer
      end else if (discard > 0) begin
        discard--;
      end else if (!drop) begin
        e.inst = I_MEM_ERR ? NOP_INST : inst_of(a);
        e.pc   = a;
        e.err  = I_MEM_ERR;
        expq.push_back(e);
        if (I_MEM_ERR) drop = 1;
      end
    end
    if (redir_req) begin
      expq.delete();
      discard    = memq.size();
      drop       = 0;
      exp_addr   = redir_exp;
      err_popped = 0;
`ifdef PEAK_FETCH_MISALIGN_EN
      if (redir_pc[1:0] != 2'b00) begin
        e.inst = NOP_INST;
        e.pc   = redir_pc;
        e.err  = 1'b1;
        expq.push_back(e);
        drop = 1;
      end
`endif
      redir_req = 0;
    end
    #1;
    if (REDIRECT) check1("req_low_on_redirect", I_MEM_REQ, 1'b0);
    if (prev_req && !prev_gnt && !REDIRECT && !prev_errpop) begin
      check1("req_stable", I_MEM_REQ, 1'b1);
      check32("addr_stable", I_MEM_ADDR, prev_addr);
    end
    if (I_MEM_REQ) req_seen++;
    if (I_MEM_REQ && I_MEM_GNT) begin
      check32("fetch_addr", I_MEM_ADDR, exp_addr);
      if (last_gnt_addr == 32'hFFFF_FFFC && I_MEM_ADDR == 32'h0) wrap_seen = 1;
      last_gnt_addr = I_MEM_ADDR;
      memq.push_back(I_MEM_ADDR);
      exp_addr = exp_addr + 32'd4;
      grants++;
    end
    prev_errpop = 0;
    if (IF_VALID && IF_READY && !REDIRECT) begin
      pops++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got pc %h expected no entry", IF_PC);
      end else begin
        e = expq.pop_front();
        check32("if_pc", IF_PC, e.pc);
        check32("if_inst", IF_INST, e.inst);
        check1("if_err", IF_ERR, e.err);
      end
      if (!first_seen) begin
        first_seen = 1;
        first_pc   = IF_PC;
      end
      if (IF_ERR) begin
        prev_errpop = 1;
        err_popped  = 1;
      end
    end
    if (err_popped && !prev_errpop && I_MEM_REQ) req_after_err++;
    prev_req  = I_MEM_REQ;
    prev_gnt  = I_MEM_GNT;
    prev_addr = I_MEM_ADDR;
  endtask

  task automatic redirect(input logic [31:0] pc, input logic [31:0] exp);
    redir_req  = 1;
    redir_pc   = pc;
    redir_exp  = exp;
    first_seen = 0;
    tick();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    REDIRECT = 1'b0; I_MEM_RVALID = 1'b0; I_MEM_GNT = 1'b0; I_MEM_ERR = 1'b0; IF_READY = 1'b0;
    #1;
    check1("rst_req", I_MEM_REQ, 1'b0);
    check32("rst_addr", I_MEM_ADDR, 32'h0);
    check1("rst_valid", IF_VALID, 1'b0);
    check32("rst_inst", IF_INST, 32'h0);
    check32("rst_pc", IF_PC, 32'h0);
    check1("rst_err", IF_ERR, 1'b0);
    expq.delete();
    discard = memq.size();
    drop = 0; exp_addr = 32'h0; prev_req = 0; prev_errpop = 0; err_popped = 0; first_seen = 0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check1("boot_no_req", I_MEM_REQ, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{tgt: 32'h0000_0040, exp_pc: 32'h0000_0040, hold: 1'b0};
    tbl[1] = '{tgt: 32'h0000_0100, exp_pc: 32'h0000_0100, hold: 1'b1};
`ifdef PEAK_FETCH_MISALIGN_EN
    tbl[2] = '{tgt: 32'h0000_2004, exp_pc: 32'h0000_2004, hold: 1'b0};
`else
    tbl[2] = '{tgt: 32'h0000_2003, exp_pc: 32'h0000_2000, hold: 1'b0};
`endif
    tbl[3] = '{tgt: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8, hold: 1'b1};

    do_reset();

    // Straight-line fetch after reset with a single-cycle memory.
    gnt_en = 1; rdy = 1;
    repeat (4) tick();
    check1("first_entry_seen", first_seen, 1'b1);
    check32("first_pc_after_reset", first_pc, 32'h0);
    pops = 0;
    repeat (20) tick();
    check32("throughput_20_cycles", 32'(pops), 32'd20);

    // Bus error on PC 8: NOP error entry, then no requests until redirect.
    err_en = 1; err_pc = 32'h8;
    redirect(32'h0, 32'h0);
    req_after_err = 0;
    repeat (15) tick();
    check1("error_entry_accepted", err_popped, 1'b1);
    check32("req_after_error", 32'(req_after_err), 32'd0);
    check1("valid_in_fault", IF_VALID, 1'b0);
    err_en = 0;

    // Redirect table: optional outstanding requests, then restart.
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].hold) begin
        mem_hold = 1;
        repeat (4) tick();
        check32("outstanding_before_redirect", 32'(memq.size()), 32'(DEPTH));
      end
      redirect(tbl[i].tgt, tbl[i].exp_pc);
      mem_hold = 0;
      tick();
      check1("valid_low_after_redirect", IF_VALID, 1'b0);
      repeat (12) tick();
      check1("entry_after_redirect", first_seen, 1'b1);
      check32("first_pc_after_redirect", first_pc, tbl[i].exp_pc);
    end
    check1("fetch_addr_wrapped", wrap_seen, 1'b1);

    // Decode stalled for 10 cycles: only DEPTH requests may be granted.
    rdy = 0;
    redirect(32'h200, 32'h200);
    grants = 0;
    repeat (10) tick();
    check32("grants_while_stalled", 32'(grants), 32'(DEPTH));
    check1("req_low_when_full", I_MEM_REQ, 1'b0);
    check32("entries_held", 32'(expq.size()), 32'(DEPTH));
    first_seen = 0;
    rdy = 1;
    repeat (6) tick();
    check32("first_pc_after_stall", first_pc, 32'h200);

    // Random grant / ready pressure, checked entry by entry.
    redirect(32'h1000, 32'h1000);
    gnt_rand = 1; rdy_rand = 1;
    repeat (60) tick();
    gnt_rand = 0; rdy_rand = 0;

`ifdef PEAK_FETCH_MISALIGN_EN
    redirect(32'h0000_0102, 32'h0000_0102);
    req_seen = 0;
    repeat (6) tick();
    check32("misaligned_no_request", 32'(req_seen), 32'd0);
    check32("misaligned_pc", first_pc, 32'h0000_0102);
    check1("misaligned_err_seen", err_popped, 1'b1);
    redirect(32'h0, 32'h0);
    repeat (6) tick();
`endif

    // Reset in the middle of streaming; a stale response must be ignored.
    repeat (3) tick();
    do_reset();
    repeat (6) tick();
    check32("first_pc_after_midreset", first_pc, 32'h0);

    // Stop granting so everything drains.
    gnt_en = 0;
    repeat (6) tick();
    check32("scoreboard_drained", 32'(expq.size()), 32'd0);
    check32("memory_drained", 32'(memq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_fetch.md
PEAK_FETCH -- requirements
Module: peak_fetch

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, 2, instruction-buffer entries and maximum outstanding requests; legal values 2 or 4.
REQ-003 CLK  in  1  sole clock; all state on rising edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 I_MEM_REQ  out  1  fetch request valid.
REQ-006 I_MEM_ADDR  out  32  fetch word address.
REQ-007 I_MEM_GNT  in  1  request accepted this cycle when high with I_MEM_REQ.
REQ-008 I_MEM_RVALID  in  1  response valid; responses return in request order, one per grant.
REQ-009 I_MEM_RDATA  in  32  instruction word.
REQ-010 I_MEM_ERR  in  1  bus error qualified by I_MEM_RVALID.
REQ-011 REDIRECT  in  1  flush and restart at REDIRECT_PC (branch, jump, trap, MRET).
REQ-012 REDIRECT_PC  in  32  new fetch address.
REQ-013 IF_VALID  out  1  IF_INST/IF_PC valid to decode stage.
REQ-014 IF_READY  in  1  decode stage accepts when high with IF_VALID.
REQ-015 IF_INST  out  32  instruction word (INST_CODE of decoder).
REQ-016 IF_PC  out  32  address of IF_INST.
REQ-017 IF_ERR  out  1  entry carries bus error; IF_INST forced 32'h0000_0013 (NOP).

Function
REQ-018 FSM states BOOT, RUN, FAULT; BOOT -> RUN one cycle after reset release; RUN -> FAULT when an error entry is accepted by decode; FAULT -> RUN only on REDIRECT.
REQ-019 I_MEM_REQ high only in RUN, REDIRECT low, and (buffer count + outstanding) < BUF_DEPTH.
REQ-020 I_MEM_ADDR holds fetch PC; fetch PC increments by 4 on each grant, 32-bit wrap from 32'hFFFF_FFFC to 0.
REQ-021 I_MEM_REQ and I_MEM_ADDR remain stable until granted, except on REDIRECT.
REQ-022 Each non-killed response is written to buffer with its PC; FIFO order.
REQ-023 IF_VALID = buffer non-empty; entry pops when IF_VALID & IF_READY; output is head entry, zero added latency (combinational from head).
REQ-024 Minimum latency: response at cycle N visible on IF_VALID at cycle N+1.
REQ-025 Full throughput: one instruction per cycle with single-cycle memory and IF_READY high.
REQ-026 Simultaneous push and pop on full buffer is legal; count unchanged.
REQ-027 REDIRECT: buffer cleared next cycle, fetch PC = REDIRECT_PC, outstanding count copied into kill counter; IF_VALID low the following cycle.
REQ-028 Killed responses decrement kill counter and are discarded; new requests permitted while kill counter non-zero.
REQ-029 REDIRECT has priority over same-cycle pop, push and grant; a same-cycle grant is counted as outstanding and killed.
REQ-030 Error entry stops further requests after acceptance; entries behind it are discarded.

Reset
REQ-031 Reset values: I_MEM_REQ 0, I_MEM_ADDR RESET_VECTOR, IF_VALID 0, IF_INST 0, IF_PC 0, IF_ERR 0, state BOOT, counters 0.
REQ-032 Reset mid-transaction discards all buffered and outstanding state; responses arriving after reset release without a grant are ignored.

Configuration
REQ-033 Macro PEAK_FETCH_MISALIGN_EN: when defined, REDIRECT_PC[1:0] != 0 produces one buffer entry with IF_ERR=1, IF_PC=REDIRECT_PC, no memory request, then FAULT; when undefined, REDIRECT_PC[1:0] is forced to 0.

Structure
REQ-034 Shared package peak_pkg holds NOP constant 32'h0000_0013, state enum, and fetch-entry struct {inst, pc, err}.
REQ-035 One sub-module peak_fetch_fifo (parameterised depth, push/pop/flush, count) implements the buffer.

Verification
REQ-036 Reset release, 1-cycle memory, IF_READY=1 -> I_MEM_ADDR 0,4,8,...; IF_PC 0,4,8 on consecutive cycles.
REQ-037 IF_READY=0 for 10 cycles -> exactly BUF_DEPTH requests granted, I_MEM_REQ low after, no entry lost when IF_READY returns.
REQ-038 REDIRECT to 32'h0000_0100 with 2 outstanding -> both responses discarded, next IF_PC 32'h0000_0100.
REQ-039 I_MEM_ERR on PC 8 -> IF_ERR=1, IF_INST=32'h0000_0013, no further requests until REDIRECT.
REQ-040 Fetch PC 32'hFFFF_FFFC -> next I_MEM_ADDR 32'h0000_0000.
REQ-041 PEAK_FETCH_MISALIGN_EN defined, REDIRECT_PC 32'h0000_0102 -> IF_ERR=1, IF_PC 32'h0000_0102, no request issued.
